// File: rtl/div_layer_signed_seq.sv
// Sequential signed restoring divider: one quotient bit per cycle, valid/ready on both sides.
// Optional DIV_ZERO_FASTPATH_EN: a zero divisor skips the iterations and retires straight after capture.
module div_layer_signed_seq #(
    parameter int width1 = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [width1-1:0] dividend,
    input  logic [width1-1:0] divisor,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [width1-1:0] quotient,
    output logic [width1-1:0] remainder,
    output logic              div_by_zero
);
    localparam int CW = $clog2(width1);

    typedef enum logic [2:0] {IDLE, LOAD, CALC, FIX, DONE} state_t;

    state_t            state;
    logic [width1-1:0] dvd_raw, dsr_raw;
    logic [width1-1:0] dvd, dsr;
    logic [width1:0]   rem;
    logic [CW-1:0]     cnt;
    logic              sign_q, sign_r, zero;

    // {rem, dvd} shifted left one place; trial sign bit decides the quotient bit
    logic [width1+1:0] rem_sh, trial;
    assign rem_sh = {rem, dvd[width1-1]};
    assign trial  = rem_sh - {2'b00, dsr};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            dvd_raw     <= '0;
            dsr_raw     <= '0;
            dvd         <= '0;
            dsr         <= '0;
            rem         <= '0;
            cnt         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            zero        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    dvd_raw  <= dividend;
                    dsr_raw  <= divisor;
                    sign_q   <= dividend[width1-1] ^ divisor[width1-1];
                    sign_r   <= dividend[width1-1];
                    zero     <= (divisor == '0);
                    in_ready <= 1'b0;
                    state    <= LOAD;
                end
                LOAD: begin
                    // most negative operand maps to 2^(width1-1), still exact as unsigned
                    dvd <= dvd_raw[width1-1] ? -dvd_raw : dvd_raw;
                    dsr <= dsr_raw[width1-1] ? -dsr_raw : dsr_raw;
                    rem <= '0;
                    cnt <= CW'(width1 - 1);
`ifdef DIV_ZERO_FASTPATH_EN
                    if (zero) begin
                        quotient    <= '1;
                        remainder   <= dvd_raw;
                        div_by_zero <= 1'b1;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        state <= CALC;
                    end
`else
                    state <= CALC;
`endif
                end
                CALC: begin
                    if (!trial[width1+1]) begin
                        rem <= trial[width1:0];
                        dvd <= {dvd[width1-2:0], 1'b1};
                    end else begin
                        rem <= rem_sh[width1:0];
                        dvd <= {dvd[width1-2:0], 1'b0};
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= FIX;
                end
                FIX: begin
                    if (zero) begin
                        quotient    <= '1;
                        remainder   <= dvd_raw;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= sign_q ? -dvd : dvd;
                        remainder   <= sign_r ? -rem[width1-1:0] : rem[width1-1:0];
                        div_by_zero <= 1'b0;
                    end
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_layer_signed_seq.sv
// Randomized and directed checks of div_layer_signed_seq against Verilog-style signed / and %.
module tb_div_layer_signed_seq;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend, divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient, remainder;
    logic       div_by_zero;

    int n_chk  = 0;
    int n_pass = 0;

    div_layer_signed_seq #(.width1(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
        .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // reference: truncating division, remainder follows dividend sign
    function automatic void model(input logic signed [7:0] a, input logic signed [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r, output logic z);
        int ai, bi;
        ai = int'(a);
        bi = int'(b);
        if (bi == 0) begin
            q = 8'hFF; r = a; z = 1'b1;
        end else begin
            q = 8'(ai / bi); r = 8'(ai % bi); z = 1'b0;
        end
    endfunction

    // called #1 after a rising edge; leaves the bench #1 after a rising edge
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int hold);
        logic [7:0] eq, er;
        logic       ez;
        int         lat, exp_lat;
        model(a, b, eq, er, ez);
`ifdef DIV_ZERO_FASTPATH_EN
        exp_lat = (b == 8'd0) ? 1 : 10;
`else
        exp_lat = 10;
`endif
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; dividend = a; divisor = b; out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = $urandom_range(0, 1); dividend = 8'($urandom); divisor = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        in_valid = 1'b0;
        chk("latency", lat, exp_lat);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_by_zero", div_by_zero, ez);
        chk("in_ready_busy", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_q", quotient, eq);
            chk("hold_r", remainder, er);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("retire_valid", out_valid, 0);
        chk("retire_in_ready", in_ready, 1);
        out_ready = 1'b0;
    endtask

    initial begin
        int seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = 8'd0; divisor = 8'd0;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        rst = 1'b0;

        do_op(8'd100, 8'd7, 0);
        do_op(-8'sd100, 8'd7, 0);
        do_op(8'd100, -8'sd7, 0);
        do_op(-8'sd100, -8'sd7, 0);
        do_op(8'h80, 8'hFF, 0);
        do_op(8'h80, 8'd1, 0);
        do_op(8'd5, 8'd9, 0);
        do_op(8'd42, 8'd0, 0);
        do_op(8'h80, 8'd0, 2);
        do_op(8'd100, 8'd7, 5);
        do_op(8'd27, 8'd4, 0);

        // reset in the middle of an iteration sequence
        in_valid = 1'b1; dividend = 8'd100; divisor = 8'd7; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_q", quotient, 0);
        seen = 0;
        repeat (15) begin @(posedge clk); #1; if (out_valid) seen++; end
        chk("midrst_no_result", seen, 0);
        out_ready = 1'b0;
        do_op(8'd9, 8'd2, 0);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom);
            b = (i % 4 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            if (i % 7 == 0) b = 8'hFF;
            do_op(a, b, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
